// File: rtl/sonic_tx_page_ring_66.sv
// Transmit page ring: DMA owords fill 4 KiB pages of 496 66-bit blocks, which are streamed
// to the gearbox in strict ring order with idle insertion on underflow and page release credits.
module sonic_tx_page_ring_66 #(
   parameter int unsigned  NUM_PAGES  = 32,
   parameter logic [65:0]  IDLE_BLOCK = 66'h0_0000_0000_0000_0079,
   parameter int unsigned  UFLOW_W    = 16,
   localparam int unsigned PW         = $clog2(NUM_PAGES)
) (
   input  logic               clk_in,
   input  logic               reset_n,
   input  logic [127:0]       i_wr_data,
   input  logic [PW+7:0]      i_wr_addr,
   input  logic               i_wr_req,
   input  logic               i_commit,
   input  logic [PW-1:0]      i_commit_page,
   input  logic               i_rd_ena,
   input  logic               i_rd_req,
   output logic [65:0]        o_data_out,
   output logic               o_data_valid,
   output logic               o_is_idle,
   output logic               o_release,
   output logic [PW-1:0]      o_release_page,
   output logic [PW:0]        o_ready_count,
   output logic [UFLOW_W-1:0] o_uflow_cnt,
   output logic               o_wr_err,
   output logic               o_commit_err
);

   localparam int unsigned CW        = PW + 1;
   localparam int unsigned BW        = 9;
   localparam int unsigned MEM_DEPTH = NUM_PAGES * 256;
   localparam int unsigned FIRST_BLK = 16;
   localparam int unsigned LAST_BIDX = 495;

   typedef enum logic {
      S_IDLE_OUT = 1'b0,
      S_STREAM   = 1'b1
   } state_t;

   // page storage, one 128-bit oword per entry, addressed {page, oword}
   logic [127:0]         r_mem [MEM_DEPTH];

   state_t               r_state;
   logic [NUM_PAGES-1:0] r_ready;
   logic [PW-1:0]        r_rptr;
   logic [BW-1:0]        r_bidx;
   logic [65:0]          r_dout;
   logic                 r_dvalid;
   logic                 r_idle;
   logic                 r_release;
   logic [PW-1:0]        r_release_page;
   logic [CW-1:0]        r_cnt;
   logic [UFLOW_W-1:0]   r_uflow;
   logic                 r_wr_err;
   logic                 r_commit_err;

   state_t               w_state_nxt;
   logic [NUM_PAGES-1:0] w_ready_nxt;
   logic [PW-1:0]        w_rptr_nxt;
   logic [BW-1:0]        w_bidx_nxt;
   logic [65:0]          w_dout_nxt;
   logic                 w_dvalid_nxt;
   logic                 w_idle_nxt;
   logic                 w_release_nxt;
   logic [PW-1:0]        w_release_page_nxt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [UFLOW_W-1:0]   w_uflow_nxt;

   logic                 w_rd_acc;
   logic [BW-1:0]        w_blk_int;
   logic [127:0]         w_data_word;
   logic [127:0]         w_sync_word;
   logic [1:0]           w_sync;
   logic [65:0]          w_block;
   logic [PW-1:0]        w_rptr_inc;
   logic [PW-1:0]        w_wr_page;
   logic                 w_wr_ok;
   logic                 w_wr_err_nxt;
   logic                 w_commit_ok;
   logic                 w_commit_err_nxt;

   assign w_rd_acc         = i_rd_ena & i_rd_req;
   assign w_rptr_inc       = r_rptr + PW'(1);
   assign w_wr_page        = i_wr_addr[PW+7:8];
   assign w_wr_ok          = i_wr_req & ~r_ready[w_wr_page];
   assign w_wr_err_nxt     = i_wr_req & r_ready[w_wr_page];
   assign w_commit_ok      = i_commit & ~r_ready[i_commit_page];
   assign w_commit_err_nxt = i_commit & r_ready[i_commit_page];

   // block lookup: data half from oword blk/2, sync pair from oword blk/64
   assign w_blk_int   = BW'(FIRST_BLK) + r_bidx;
   assign w_data_word = r_mem[{r_rptr, w_blk_int[8:1]}];
   assign w_sync_word = r_mem[{r_rptr, 5'd0, w_blk_int[8:6]}];
   assign w_sync      = w_sync_word[{w_blk_int[5:0], 1'b0} +: 2];
   assign w_block     = {(w_blk_int[0] ? w_data_word[127:64] : w_data_word[63:0]), w_sync};

   // writes to a ready page are dropped; reads see pre-edge contents
   always_ff @(posedge clk_in) begin
      if (w_wr_ok) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE_OUT;
         r_ready        <= '0;
         r_rptr         <= '0;
         r_bidx         <= '0;
         r_dout         <= '0;
         r_dvalid       <= 1'b0;
         r_idle         <= 1'b0;
         r_release      <= 1'b0;
         r_release_page <= '0;
         r_cnt          <= '0;
         r_uflow        <= '0;
         r_wr_err       <= 1'b0;
         r_commit_err   <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_ready        <= w_ready_nxt;
         r_rptr         <= w_rptr_nxt;
         r_bidx         <= w_bidx_nxt;
         r_dout         <= w_dout_nxt;
         r_dvalid       <= w_dvalid_nxt;
         r_idle         <= w_idle_nxt;
         r_release      <= w_release_nxt;
         r_release_page <= w_release_page_nxt;
         r_cnt          <= w_cnt_nxt;
         r_uflow        <= w_uflow_nxt;
         r_wr_err       <= w_wr_err_nxt;
         r_commit_err   <= w_commit_err_nxt;
      end
   end

   // read FSM, release/commit bookkeeping and ready count
   always_comb begin
      w_state_nxt        = r_state;
      w_ready_nxt        = r_ready;
      w_rptr_nxt         = r_rptr;
      w_bidx_nxt         = r_bidx;
      w_dout_nxt         = r_dout;
      w_dvalid_nxt       = 1'b0;
      w_idle_nxt         = 1'b0;
      w_release_nxt      = 1'b0;
      w_release_page_nxt = r_release_page;
      w_cnt_nxt          = r_cnt;
      w_uflow_nxt        = r_uflow;

      if (w_rd_acc) begin
         w_dvalid_nxt = 1'b1;
         case (r_state)
            S_IDLE_OUT: begin
               if (r_ready[r_rptr]) begin
                  w_dout_nxt  = w_block;
                  w_bidx_nxt  = BW'(1);
                  w_state_nxt = S_STREAM;
               end else begin
                  w_dout_nxt = IDLE_BLOCK;
                  w_idle_nxt = 1'b1;
                  if (r_uflow != {UFLOW_W{1'b1}}) begin
                     w_uflow_nxt = r_uflow + UFLOW_W'(1);
                  end
               end
            end
            S_STREAM: begin
               w_dout_nxt = w_block;
               if (r_bidx == BW'(LAST_BIDX)) begin
                  w_ready_nxt[r_rptr] = 1'b0;
                  w_release_nxt       = 1'b1;
                  w_release_page_nxt  = r_rptr;
                  w_rptr_nxt          = w_rptr_inc;
                  w_bidx_nxt          = '0;
                  // keep streaming without a bubble when the next page is already ready
                  if (!r_ready[w_rptr_inc]) begin
                     w_state_nxt = S_IDLE_OUT;
                  end
               end else begin
                  w_bidx_nxt = r_bidx + BW'(1);
               end
            end
            default: begin
               w_state_nxt = S_IDLE_OUT;
            end
         endcase
      end

      if (w_commit_ok) begin
         w_ready_nxt[i_commit_page] = 1'b1;
      end

      case ({w_commit_ok, w_release_nxt})
         2'b10:   w_cnt_nxt = r_cnt + CW'(1);
         2'b01:   w_cnt_nxt = r_cnt - CW'(1);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   assign o_data_out     = r_dout;
   assign o_data_valid   = r_dvalid;
   assign o_is_idle      = r_idle;
   assign o_release      = r_release;
   assign o_release_page = r_release_page;
   assign o_ready_count  = r_cnt;
   assign o_uflow_cnt    = r_uflow;
   assign o_wr_err       = r_wr_err;
   assign o_commit_err   = r_commit_err;

endmodule

// File: tb/tb_sonic_tx_page_ring_66.sv
// Bench for sonic_tx_page_ring_66 (4 pages, 4-bit underflow counter) against a per-block page model.
module tb_sonic_tx_page_ring_66;

   localparam int unsigned NP   = 4;
   localparam int unsigned UW   = 4;
   localparam int unsigned NBLK = 496;
   localparam logic [65:0] IDLE = 66'h79;

   logic         clk_in  = 1'b0;
   logic         reset_n = 1'b1;
   logic [127:0] i_wr_data     = '0;
   logic [9:0]   i_wr_addr     = '0;
   logic         i_wr_req      = 1'b0;
   logic         i_commit      = 1'b0;
   logic [1:0]   i_commit_page = '0;
   logic         i_rd_ena      = 1'b0;
   logic         i_rd_req      = 1'b0;
   logic [65:0]  o_data_out;
   logic         o_data_valid;
   logic         o_is_idle;
   logic         o_release;
   logic [1:0]   o_release_page;
   logic [2:0]   o_ready_count;
   logic [UW-1:0] o_uflow_cnt;
   logic         o_wr_err;
   logic         o_commit_err;

   always #5 clk_in = ~clk_in;

   sonic_tx_page_ring_66 #(
      .NUM_PAGES  (NP),
      .IDLE_BLOCK (IDLE),
      .UFLOW_W    (UW)
   ) dut (
      .clk_in         (clk_in),
      .reset_n        (reset_n),
      .i_wr_data      (i_wr_data),
      .i_wr_addr      (i_wr_addr),
      .i_wr_req       (i_wr_req),
      .i_commit       (i_commit),
      .i_commit_page  (i_commit_page),
      .i_rd_ena       (i_rd_ena),
      .i_rd_req       (i_rd_req),
      .o_data_out     (o_data_out),
      .o_data_valid   (o_data_valid),
      .o_is_idle      (o_is_idle),
      .o_release      (o_release),
      .o_release_page (o_release_page),
      .o_ready_count  (o_ready_count),
      .o_uflow_cnt    (o_uflow_cnt),
      .o_wr_err       (o_wr_err),
      .o_commit_err   (o_commit_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // model: each page is a list of blocks indexed by internal position 0..511
   logic [1:0]    m_sync [NP][512];
   logic [63:0]   m_data [NP][512];
   logic [NP-1:0] m_ready;
   int            m_rptr, m_pos, m_uflow;
   logic [65:0]   e_dout;
   logic          e_valid, e_idle, e_rel, e_werr, e_cerr;
   int            e_relp;
   int            rel_log[$];

   typedef struct {
      logic         wreq;
      logic [9:0]   waddr;
      logic [127:0] wdata;
      logic         cm;
      logic [1:0]   cp;
      logic         ren;
      logic         rreq;
      logic         x_valid;
      logic         x_idle;
      logic [3:0]   x_uflow;
      logic [2:0]   x_cnt;
      logic         x_werr;
      logic         x_cerr;
      logic [65:0]  x_dout;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ready = '0;
      m_rptr  = 0;
      m_pos   = 0;
      m_uflow = 0;
      e_dout  = '0;
   endtask

   // one clock of stimulus; model predicts registered outputs from pre-edge state
   task automatic cycle(input logic wreq, input logic [9:0] waddr, input logic [127:0] wdata,
                        input logic cm, input logic [1:0] cp, input logic ren, input logic rreq);
      logic [NP-1:0] rdy_pre;
      int p, o;
      i_wr_req = wreq; i_wr_addr = waddr; i_wr_data = wdata;
      i_commit = cm; i_commit_page = cp; i_rd_ena = ren; i_rd_req = rreq;
      rdy_pre = m_ready;
      e_valid = 1'b0; e_idle = 1'b0; e_rel = 1'b0; e_werr = 1'b0; e_cerr = 1'b0;
      if (ren && rreq) begin
         e_valid = 1'b1;
         if (m_pos == 0 && !m_ready[m_rptr]) begin
            e_dout = IDLE;
            e_idle = 1'b1;
            if (m_uflow < (1 << UW) - 1) m_uflow++;
         end else begin
            e_dout = {m_data[m_rptr][16 + m_pos], m_sync[m_rptr][16 + m_pos]};
            m_pos++;
            if (m_pos == NBLK) begin
               e_rel = 1'b1;
               e_relp = m_rptr;
               m_ready[m_rptr] = 1'b0;
               m_rptr = (m_rptr + 1) % NP;
               m_pos = 0;
            end
         end
      end
      if (cm) begin
         if (rdy_pre[cp]) e_cerr = 1'b1;
         else m_ready[cp] = 1'b1;
      end
      if (wreq) begin
         p = int'(waddr[9:8]);
         o = int'(waddr[7:0]);
         if (rdy_pre[p]) e_werr = 1'b1;
         else if (o < 8) begin
            for (int k = 0; k < 64; k++) m_sync[p][64*o + k] = wdata[2*k +: 2];
         end else begin
            m_data[p][2*o]     = wdata[63:0];
            m_data[p][2*o + 1] = wdata[127:64];
         end
      end
      @(posedge clk_in);
      #1;
      chk("data_valid", 66'(o_data_valid), 66'(e_valid));
      chk("data_out", o_data_out, e_dout);
      chk("is_idle", 66'(o_is_idle), 66'(e_idle));
      chk("release", 66'(o_release), 66'(e_rel));
      if (e_rel) chk("release_page", 66'(o_release_page), 66'(e_relp));
      chk("ready_count", 66'(o_ready_count), 66'($countones(m_ready)));
      chk("uflow_cnt", 66'(o_uflow_cnt), 66'(m_uflow));
      chk("wr_err", 66'(o_wr_err), 66'(e_werr));
      chk("commit_err", 66'(o_commit_err), 66'(e_cerr));
      if (o_release) rel_log.push_back(int'(o_release_page));
   endtask

   task automatic rd(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
   endtask

   // pat=1: sync 01 everywhere and data = external block index
   task automatic write_page(input int p, input bit pat);
      logic [127:0] d;
      for (int o = 0; o < 256; o++) begin
         if (pat) d = (o < 8) ? {64{2'b01}} : {64'(2*o - 15), 64'(2*o - 16)};
         else     d = {$urandom(), $urandom(), $urandom(), $urandom()};
         cycle(1'b1, {2'(p), 8'(o)}, d, 1'b0, '0, 1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      i_wr_req = 1'b0; i_commit = 1'b0; i_rd_ena = 1'b0; i_rd_req = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("rst_data_out", o_data_out, '0);
      chk("rst_data_valid", 66'(o_data_valid), '0);
      chk("rst_is_idle", 66'(o_is_idle), '0);
      chk("rst_release", 66'(o_release), '0);
      chk("rst_release_page", 66'(o_release_page), '0);
      chk("rst_ready_count", 66'(o_ready_count), '0);
      chk("rst_uflow_cnt", 66'(o_uflow_cnt), '0);
      chk("rst_wr_err", 66'(o_wr_err), '0);
      chk("rst_commit_err", 66'(o_commit_err), '0);
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int peak, idles;

      tbl[0] = '{1'b0, 10'd0,   128'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 66'h79};
      tbl[1] = '{1'b0, 10'd0,   128'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0, 1'b0, 66'h79};
      tbl[2] = '{1'b0, 10'd0,   128'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0, 1'b0, 66'h79};
      tbl[3] = '{1'b0, 10'd0,   128'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 3'd0, 1'b0, 1'b0, 66'h79};
      tbl[4] = '{1'b0, 10'd0,   128'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 3'd0, 1'b0, 1'b0, 66'h79};
      tbl[5] = '{1'b0, 10'd0,   128'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 3'd1, 1'b0, 1'b0, 66'h79};
      tbl[6] = '{1'b0, 10'd0,   128'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 3'd1, 1'b0, 1'b0, 66'h1};
      tbl[7] = '{1'b1, 10'd8,   '1,     1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 3'd1, 1'b1, 1'b0, 66'h1};
      tbl[8] = '{1'b0, 10'd0,   128'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 3'd1, 1'b0, 1'b1, 66'h1};
      tbl[9] = '{1'b0, 10'd0,   128'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 3'd1, 1'b0, 1'b0, 66'h5};

      model_reset();
      do_reset();

      // underflow, commit, dropped write, double commit, then full page 0 stream
      write_page(0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cycle(tbl[i].wreq, tbl[i].waddr, tbl[i].wdata, tbl[i].cm, tbl[i].cp, tbl[i].ren, tbl[i].rreq);
         chk($sformatf("tbl%0d_valid", i), 66'(o_data_valid), 66'(tbl[i].x_valid));
         chk($sformatf("tbl%0d_idle", i), 66'(o_is_idle), 66'(tbl[i].x_idle));
         chk($sformatf("tbl%0d_uflow", i), 66'(o_uflow_cnt), 66'(tbl[i].x_uflow));
         chk($sformatf("tbl%0d_cnt", i), 66'(o_ready_count), 66'(tbl[i].x_cnt));
         chk($sformatf("tbl%0d_werr", i), 66'(o_wr_err), 66'(tbl[i].x_werr));
         chk($sformatf("tbl%0d_cerr", i), 66'(o_commit_err), 66'(tbl[i].x_cerr));
         chk($sformatf("tbl%0d_dout", i), o_data_out, tbl[i].x_dout);
      end
      rel_log.delete();
      rd(NBLK - 3);
      chk("p0_last_block", o_data_out, {64'd494, 2'b01});
      chk("p0_no_early_release", 66'(rel_log.size()), 66'd0);
      rd(1);
      chk("p0_final_block", o_data_out, {64'd495, 2'b01});
      chk("p0_release", 66'(o_release), 66'd1);
      chk("p0_release_page", 66'(o_release_page), 66'd0);
      chk("p0_count_after", 66'(o_ready_count), 66'd0);

      // out-of-order commits 2,1,0 under continuous reads
      do_reset();
      for (int p = 0; p < 3; p++) write_page(p, 1'b0);
      rel_log.delete();
      cycle(1'b0, '0, '0, 1'b1, 2'd2, 1'b1, 1'b1);
      cycle(1'b0, '0, '0, 1'b1, 2'd1, 1'b1, 1'b1);
      cycle(1'b0, '0, '0, 1'b1, 2'd0, 1'b1, 1'b1);
      peak = int'(o_ready_count);
      idles = 0;
      for (int i = 0; i < 3 * NBLK; i++) begin
         rd(1);
         if (int'(o_ready_count) > peak) peak = int'(o_ready_count);
         if (o_is_idle) idles++;
      end
      chk("ooo_peak_count", 66'(peak), 66'd3);
      chk("ooo_idles_between", 66'(idles), 66'd0);
      chk("ooo_uflow", 66'(o_uflow_cnt), 66'd3);
      chk("ooo_rel_n", 66'(rel_log.size()), 66'd3);
      for (int i = 0; i < rel_log.size() && i < 3; i++) chk("ooo_rel_seq", 66'(rel_log[i]), 66'(i));

      // ring wrap across five pages
      do_reset();
      rel_log.delete();
      for (int k = 0; k < 5; k++) begin
         write_page(k % NP, 1'b0);
         cycle(1'b0, '0, '0, 1'b1, 2'(k % NP), 1'b0, 1'b0);
         rd(NBLK);
      end
      chk("wrap_rel_n", 66'(rel_log.size()), 66'd5);
      for (int i = 0; i < rel_log.size() && i < 5; i++) chk("wrap_rel_seq", 66'(rel_log[i]), 66'(i % NP));

      // reset in the middle of page 1, then underflow saturation and restart on page 0
      do_reset();
      write_page(0, 1'b0);
      write_page(1, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 2'd0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 2'd1, 1'b0, 1'b0);
      rel_log.delete();
      rd(NBLK + 200);
      do_reset();
      rd(3);
      chk("post_rst_idle", 66'(o_is_idle), 66'd1);
      chk("post_rst_dout", o_data_out, IDLE);
      rd(15);
      chk("uflow_sat", 66'(o_uflow_cnt), 66'd15);
      chk("mid_rst_rel_n", 66'(rel_log.size()), 66'd1);
      cycle(1'b0, '0, '0, 1'b1, 2'd0, 1'b0, 1'b0);
      rd(1);
      chk("restart_blk0", o_data_out, {m_data[0][16], m_sync[0][16]});
      chk("restart_not_idle", 66'(o_is_idle), 66'd0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 1)), 10'($urandom()),
               {$urandom(), $urandom(), $urandom(), $urandom()},
               1'($urandom_range(0, 39) == 0), 2'($urandom()),
               1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 7));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
